// File: rtl/alu_arbiter.sv
// alu_arbiter: two-port round-robin arbiter and sequencer in front of one
// shared combinational ALU. A command is accepted, held in operand registers
// for one execute cycle, and the ALU result is captured and returned on the
// granted requester's response channel.
`timescale 1ns/1ps
module alu_arbiter #(
   parameter int CNT_W = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   // requester 0
   input  logic              req0_valid,
   output logic              req0_ready,
   input  logic [31:0]       req0_a,
   input  logic [31:0]       req0_b,
   input  logic [3:0]        req0_sel,
   input  logic              req0_cin,
   output logic              rsp0_valid,
   input  logic              rsp0_ready,
   output logic [31:0]       rsp0_y,
   output logic [3:0]        rsp0_flags,
   output logic              rsp0_err,
   // requester 1
   input  logic              req1_valid,
   output logic              req1_ready,
   input  logic [31:0]       req1_a,
   input  logic [31:0]       req1_b,
   input  logic [3:0]        req1_sel,
   input  logic              req1_cin,
   output logic              rsp1_valid,
   input  logic              rsp1_ready,
   output logic [31:0]       rsp1_y,
   output logic [3:0]        rsp1_flags,
   output logic              rsp1_err,
   // shared ALU
   output logic [31:0]       alu_a,
   output logic [31:0]       alu_b,
   output logic [3:0]        alu_sel,
   output logic              alu_cin,
   input  logic [31:0]       alu_y,
   input  logic              alu_cout,
   input  logic              alu_neg,
   input  logic              alu_zero,
   input  logic              alu_ovf,
   // statistics
   output logic [CNT_W-1:0]  op_count
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_EXEC = 2'd1,
      S_RESP = 2'd2
   } state_t;

   localparam logic [3:0]       SEL_MAX = 4'd5;
   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   state_t            state_q, state_d;
   logic              last_grant_q, last_grant_d;
   logic              gnt_q, gnt_d;
   logic [31:0]       a_q, a_d;
   logic [31:0]       b_q, b_d;
   logic [3:0]        sel_q, sel_d;
   logic              cin_q, cin_d;
   logic [31:0]       y_q, y_d;
   logic [3:0]        flags_q, flags_d;
   logic              err_q, err_d;
   logic              rsp0_valid_q, rsp0_valid_d;
   logic              rsp1_valid_q, rsp1_valid_d;
   logic [CNT_W-1:0]  op_count_q, op_count_d;

   logic              grant_s;
   logic              accept_s;
   logic              rsp_ready_s;

   // Round-robin grant: on contention the port that was not served last wins.
   always_comb begin
      grant_s = 1'b0;
      if (req0_valid && req1_valid) begin
         grant_s = ~last_grant_q;
      end else if (req1_valid) begin
         grant_s = 1'b1;
      end else begin
         grant_s = 1'b0;
      end
   end

   assign req0_ready  = (state_q == S_IDLE) && (grant_s == 1'b0);
   assign req1_ready  = (state_q == S_IDLE) && (grant_s == 1'b1);
   assign accept_s    = (req0_valid && req0_ready) || (req1_valid && req1_ready);
   assign rsp_ready_s = gnt_q ? rsp1_ready : rsp0_ready;

   // Next-state and register-update logic for the IDLE/EXEC/RESP sequence.
   always_comb begin
      state_d      = state_q;
      last_grant_d = last_grant_q;
      gnt_d        = gnt_q;
      a_d          = a_q;
      b_d          = b_q;
      sel_d        = sel_q;
      cin_d        = cin_q;
      y_d          = y_q;
      flags_d      = flags_q;
      err_d        = err_q;
      rsp0_valid_d = rsp0_valid_q;
      rsp1_valid_d = rsp1_valid_q;
      op_count_d   = op_count_q;
      case (state_q)
         S_IDLE: begin
            if (accept_s) begin
               gnt_d   = grant_s;
               a_d     = grant_s ? req1_a   : req0_a;
               b_d     = grant_s ? req1_b   : req0_b;
               sel_d   = grant_s ? req1_sel : req0_sel;
               cin_d   = grant_s ? req1_cin : req0_cin;
               state_d = S_EXEC;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_EXEC: begin
            // Illegal opcodes never expose whatever the ALU drives for them.
            if (sel_q <= SEL_MAX) begin
               y_d     = alu_y;
               flags_d = {alu_cout, alu_neg, alu_zero, alu_ovf};
               err_d   = 1'b0;
            end else begin
               y_d     = 32'd0;
               flags_d = 4'd0;
               err_d   = 1'b1;
            end
            rsp0_valid_d = ~gnt_q;
            rsp1_valid_d = gnt_q;
            state_d      = S_RESP;
         end
         S_RESP: begin
            if (rsp_ready_s) begin
               rsp0_valid_d = 1'b0;
               rsp1_valid_d = 1'b0;
               last_grant_d = gnt_q;
               op_count_d   = op_count_q + CNT_ONE;
               state_d      = S_IDLE;
            end else begin
               state_d = S_RESP;
            end
         end
         default: begin
            rsp0_valid_d = 1'b0;
            rsp1_valid_d = 1'b0;
            state_d      = S_IDLE;
         end
      endcase
   end

   // State, operand, result and counter registers with asynchronous reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= S_IDLE;
         last_grant_q <= 1'b1;
         gnt_q        <= 1'b0;
         a_q          <= 32'd0;
         b_q          <= 32'd0;
         sel_q        <= 4'd0;
         cin_q        <= 1'b0;
         y_q          <= 32'd0;
         flags_q      <= 4'd0;
         err_q        <= 1'b0;
         rsp0_valid_q <= 1'b0;
         rsp1_valid_q <= 1'b0;
         op_count_q   <= {CNT_W{1'b0}};
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         gnt_q        <= gnt_d;
         a_q          <= a_d;
         b_q          <= b_d;
         sel_q        <= sel_d;
         cin_q        <= cin_d;
         y_q          <= y_d;
         flags_q      <= flags_d;
         err_q        <= err_d;
         rsp0_valid_q <= rsp0_valid_d;
         rsp1_valid_q <= rsp1_valid_d;
         op_count_q   <= op_count_d;
      end
   end

   assign alu_a      = a_q;
   assign alu_b      = b_q;
   assign alu_sel    = sel_q;
   assign alu_cin    = cin_q;
   assign rsp0_valid = rsp0_valid_q;
   assign rsp1_valid = rsp1_valid_q;
   assign rsp0_y     = y_q;
   assign rsp1_y     = y_q;
   assign rsp0_flags = flags_q;
   assign rsp1_flags = flags_q;
   assign rsp0_err   = err_q;
   assign rsp1_err   = err_q;
   assign op_count   = op_count_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed self-checking bench for alu_arbiter with a behavioural ALU stub.
`timescale 1ns/1ps
module tb_alu_arbiter;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req0_valid, req0_ready, req0_cin;
   logic [31:0] req0_a, req0_b;
   logic [3:0]  req0_sel;
   logic        rsp0_valid, rsp0_ready, rsp0_err;
   logic [31:0] rsp0_y;
   logic [3:0]  rsp0_flags;
   logic        req1_valid, req1_ready, req1_cin;
   logic [31:0] req1_a, req1_b;
   logic [3:0]  req1_sel;
   logic        rsp1_valid, rsp1_ready, rsp1_err;
   logic [31:0] rsp1_y;
   logic [3:0]  rsp1_flags;
   logic [31:0] alu_a, alu_b, alu_y;
   logic [3:0]  alu_sel;
   logic        alu_cin, alu_cout, alu_neg, alu_zero, alu_ovf;
   logic [15:0] op_count;

   int pass_cnt  = 0;
   int total_cnt = 0;

   always #5 clk = ~clk;

   alu_arbiter #(.CNT_W(16)) dut (
      .clk(clk), .rst_n(rst_n),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
      .req0_sel(req0_sel), .req0_cin(req0_cin),
      .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_y(rsp0_y),
      .rsp0_flags(rsp0_flags), .rsp0_err(rsp0_err),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
      .req1_sel(req1_sel), .req1_cin(req1_cin),
      .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_y(rsp1_y),
      .rsp1_flags(rsp1_flags), .rsp1_err(rsp1_err),
      .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .alu_cin(alu_cin),
      .alu_y(alu_y), .alu_cout(alu_cout), .alu_neg(alu_neg), .alu_zero(alu_zero),
      .alu_ovf(alu_ovf), .op_count(op_count)
   );

   // Behavioural ALU stub; drives junk on illegal opcodes so masking is visible.
   always_comb begin
      alu_cout = alu_cin;
      alu_ovf  = 1'b0;
      case (alu_sel)
         4'b0000: alu_y = alu_a & alu_b;
         4'b0001: alu_y = alu_a | alu_b;
         4'b0010: alu_y = ~alu_a;
         4'b0011: alu_y = ~(alu_a | alu_b);
         4'b0100: alu_y = alu_a ^ alu_b;
         4'b0101: alu_y = ~(alu_a & alu_b);
         default: begin
            alu_y    = 32'hDEADBEEF;
            alu_cout = 1'b1;
            alu_ovf  = 1'b1;
         end
      endcase
      alu_neg  = alu_y[31];
      alu_zero = (alu_y == 32'd0);
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total_cnt++;
      assert (obs === exp) pass_cnt++;
      else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst_n = 1'b0;
      req0_valid = 1'b0; req0_a = 32'd0; req0_b = 32'd0; req0_sel = 4'd0; req0_cin = 1'b0;
      req1_valid = 1'b0; req1_a = 32'd0; req1_b = 32'd0; req1_sel = 4'd0; req1_cin = 1'b0;
      rsp0_ready = 1'b0; rsp1_ready = 1'b0;
      tick(); tick();
      // reset state
      chk("rst_rsp0_valid", 32'(rsp0_valid), 32'd0);
      chk("rst_rsp1_valid", 32'(rsp1_valid), 32'd0);
      chk("rst_op_count", 32'(op_count), 32'd0);
      chk("rst_alu_a", alu_a, 32'd0);
      rst_n = 1'b1;

      // single op: AND
      req0_valid = 1'b1; req0_a = 32'hF0F0F0F0; req0_b = 32'hFF00FF00; req0_sel = 4'b0000;
      #1;
      chk("single_ready0", 32'(req0_ready), 32'd1);
      chk("single_ready1", 32'(req1_ready), 32'd0);
      tick();
      req0_valid = 1'b0;
      chk("single_alu_a", alu_a, 32'hF0F0F0F0);
      chk("single_alu_b", alu_b, 32'hFF00FF00);
      chk("single_exec_valid", 32'(rsp0_valid), 32'd0);
      tick();
      chk("single_rsp0_valid", 32'(rsp0_valid), 32'd1);
      chk("single_rsp1_valid", 32'(rsp1_valid), 32'd0);
      chk("single_y", rsp0_y, 32'hF000F000);
      chk("single_flags", 32'(rsp0_flags), 32'h4);
      chk("single_err", 32'(rsp0_err), 32'd0);
      rsp0_ready = 1'b1;
      tick();
      rsp0_ready = 1'b0;
      chk("single_done_valid", 32'(rsp0_valid), 32'd0);
      chk("single_op_count", 32'(op_count), 32'd1);

      // contention from reset: req0 XOR, req1 OR
      rst_n = 1'b0; tick(); rst_n = 1'b1;
      rsp0_ready = 1'b1; rsp1_ready = 1'b1;
      req0_valid = 1'b1; req0_a = 32'h1; req0_b = 32'h3; req0_sel = 4'b0100; req0_cin = 1'b0;
      req1_valid = 1'b1; req1_a = 32'h1; req1_b = 32'h3; req1_sel = 4'b0001; req1_cin = 1'b0;
      #1;
      chk("cont_ready0", 32'(req0_ready), 32'd1);
      chk("cont_ready1", 32'(req1_ready), 32'd0);
      tick();
      req0_valid = 1'b0;
      chk("cont_exec_ready1", 32'(req1_ready), 32'd0);
      tick();
      chk("cont_rsp0_valid", 32'(rsp0_valid), 32'd1);
      chk("cont_rsp1_quiet", 32'(rsp1_valid), 32'd0);
      chk("cont_y0", rsp0_y, 32'h2);
      tick();
      chk("cont_rsp0_done", 32'(rsp0_valid), 32'd0);
      chk("cont_idle_ready1", 32'(req1_ready), 32'd1);
      tick();
      chk("cont_exec1_alu_sel", 32'(alu_sel), 32'h1);
      chk("cont_exec1_rsp1", 32'(rsp1_valid), 32'd0);
      tick();
      req1_valid = 1'b0;
      chk("cont_rsp1_valid", 32'(rsp1_valid), 32'd1);
      chk("cont_rsp0_quiet", 32'(rsp0_valid), 32'd0);
      chk("cont_y1", rsp1_y, 32'h3);
      tick();
      chk("cont_op_count", 32'(op_count), 32'd2);

      // fairness: both held valid for six operations
      rst_n = 1'b0; tick(); rst_n = 1'b1;
      req0_valid = 1'b1; req1_valid = 1'b1;
      #1;
      for (int k = 0; k < 6; k++) begin
         chk("fair_ready_owner", 32'((k % 2 == 0) ? req0_ready : req1_ready), 32'd1);
         tick();
         tick();
         chk("fair_rsp0_valid", 32'(rsp0_valid), 32'((k % 2 == 0) ? 1 : 0));
         chk("fair_rsp1_valid", 32'(rsp1_valid), 32'((k % 2 == 0) ? 0 : 1));
         chk("fair_y", rsp0_y, (k % 2 == 0) ? 32'h2 : 32'h3);
         tick();
      end
      req0_valid = 1'b0; req1_valid = 1'b0;
      chk("fair_op_count", 32'(op_count), 32'd6);

      // backpressure on port 0 (last grant was 1, so port 0 is preferred)
      rsp0_ready = 1'b0; rsp1_ready = 1'b1;
      req0_valid = 1'b1; req0_a = 32'hA5A50000; req0_b = 32'h0F0FFFFF; req0_sel = 4'b0000; req0_cin = 1'b1;
      tick();
      req0_valid = 1'b0;
      req1_valid = 1'b1; req1_a = 32'h55555555; req1_sel = 4'b0010;
      tick();
      for (int k = 0; k < 10; k++) begin
         chk("bp_rsp0_valid", 32'(rsp0_valid), 32'd1);
         chk("bp_y", rsp0_y, 32'h05050000);
         chk("bp_flags", 32'(rsp0_flags), 32'h8);
         chk("bp_ready0", 32'(req0_ready), 32'd0);
         chk("bp_ready1", 32'(req1_ready), 32'd0);
         chk("bp_alu_a", alu_a, 32'hA5A50000);
         tick();
      end
      rsp0_ready = 1'b1;
      tick();
      chk("bp_released_valid", 32'(rsp0_valid), 32'd0);
      chk("bp_idle_ready1", 32'(req1_ready), 32'd1);
      req1_valid = 1'b0;
      chk("bp_op_count", 32'(op_count), 32'd7);

      // illegal opcode, then zero result
      req0_valid = 1'b1; req0_a = 32'hFFFFFFFF; req0_b = 32'h1; req0_sel = 4'b1010; req0_cin = 1'b1;
      tick();
      req0_valid = 1'b0;
      tick();
      chk("ill_y", rsp0_y, 32'd0);
      chk("ill_flags", 32'(rsp0_flags), 32'd0);
      chk("ill_err", 32'(rsp0_err), 32'd1);
      tick();
      req0_valid = 1'b1; req0_a = 32'd0; req0_b = 32'd0; req0_sel = 4'b0000; req0_cin = 1'b0;
      #1;
      chk("zero_ready0", 32'(req0_ready), 32'd1);
      tick();
      req0_valid = 1'b0;
      tick();
      chk("zero_y", rsp0_y, 32'd0);
      chk("zero_flags", 32'(rsp0_flags), 32'h2);
      chk("zero_err", 32'(rsp0_err), 32'd0);
      tick();
      chk("zero_op_count", 32'(op_count), 32'd9);

      // reset during EXEC drops the command
      req1_valid = 1'b1; req1_a = 32'h12345678; req1_b = 32'hFFFF0000; req1_sel = 4'b0100; req1_cin = 1'b0;
      tick();
      chk("rmid_alu_a", alu_a, 32'h12345678);
      #1 rst_n = 1'b0;
      #1;
      chk("rmid_rsp1_valid", 32'(rsp1_valid), 32'd0);
      chk("rmid_op_count", 32'(op_count), 32'd0);
      chk("rmid_alu_a_zero", alu_a, 32'd0);
      chk("rmid_alu_sel_zero", 32'(alu_sel), 32'd0);
      tick();
      rst_n = 1'b1;
      #1;
      chk("rmid_ready1", 32'(req1_ready), 32'd1);
      tick();
      req1_valid = 1'b0;
      tick();
      chk("rmid_rsp1_after", 32'(rsp1_valid), 32'd1);
      chk("rmid_y", rsp1_y, 32'hEDCB5678);
      chk("rmid_flags", 32'(rsp1_flags), 32'h4);
      tick();
      chk("rmid_op_count_after", 32'(op_count), 32'd1);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Two-port round-robin arbiter and sequencer that shares one combinational `ALU` instance (32-bit A/B, 4-bit `sel`, `Cin`; outputs Y, Cout, Negative, Zero, Overflow) between two independent requesters.
- Each request is a valid/ready command carrying operands, `sel` and `Cin`.
- The block registers the command, drives the ALU from stable registered operands for one execute cycle, and captures Y plus flags.
- It then returns the result to the granted requester on a valid/ready response channel.
- It sits directly beside the `ALU` instance; the ALU ports are wired straight to the `alu_*` ports below.

## Interface
Parameters:
- `CNT_W`, 16, width of the completed-operation counter.

Ports (i ∈ {0,1}):
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `reqi_valid`  in  1  requester i has a command.
- `reqi_ready`  out  1  command accepted this cycle when `reqi_valid & reqi_ready`.
- `reqi_a`, `reqi_b`  in  32  operands.
- `reqi_sel`  in  4  ALU opcode: 0000 AND, 0001 OR, 0010 NOT(A), 0011 NOR, 0100 XOR, 0101 NAND; 0110–1111 illegal.
- `reqi_cin`  in  1  carry-in, forwarded unchanged.
- `rspi_valid`  out  1  result available for requester i.
- `rspi_ready`  in  1  requester i consumes the result.
- `rspi_y`  out  32  result.
- `rspi_flags`  out  4  {Cout, Negative, Zero, Overflow}.
- `rspi_err`  out  1  command had an illegal `sel`.
- `alu_a`, `alu_b`  out  32  to ALU A, B.
- `alu_sel`  out  4  to ALU sel.
- `alu_cin`  out  1  to ALU Cin.
- `alu_y`  in  32  from ALU Y.
- `alu_cout`, `alu_neg`, `alu_zero`, `alu_ovf`  in  1 each  from ALU.
- `op_count`  out  CNT_W  number of completed responses; wraps modulo 2^CNT_W.

## Operation
- State machine IDLE → EXEC → RESP → IDLE.
- IDLE:
  - Grant is combinational from the valids. Only one valid: that requester wins. Both valid: the requester not equal to `last_grant` wins.
  - `reqi_ready` = (state==IDLE) & (grant==i). At most one ready is high; ready may depend on the other port's valid.
  - On handshake: latch a, b, sel, cin and grant ID into operand registers; go EXEC.
  - No valid: stay in IDLE.
- EXEC (exactly 1 cycle):
  - `alu_*` outputs are the operand registers; they hold stable from the EXEC entry edge until the next accept.
  - At the EXEC→RESP edge, capture `alu_y` and the four flags into result registers.
  - If sel is illegal: capture y=0, flags=0, err=1. Legal sel: err=0.
- RESP:
  - `rsp[grant]_valid`=1; the other rsp_valid=0.
  - `rspi_y`, `rspi_flags` and `rspi_err` show the result registers on both ports. They are meaningful only with valid.
  - On `rsp[grant]_ready`: set `last_grant`←grant, increment `op_count`, go IDLE.
  - Otherwise hold every output unchanged indefinitely.
- `rspi_ready` on the non-granted port is ignored.
- `reqi_*` changes while not ready are ignored. Commands are never queued; the requester must hold valid until ready.
- Reset (async assert, any state): state=IDLE, `last_grant`=1 (requester 0 wins first contention), operand/result registers=0, `alu_*`=0, all rsp_valid=0, `op_count`=0. An in-flight command is dropped with no response.

## Timing
- Accept at edge N: EXEC during cycle N+1, response valid from cycle N+2.
- Response consumed at edge M: IDLE in cycle M+1, and the next accept is possible at edge M+1.
- Minimum spacing between accepts is 3 cycles.
- Outputs are all registered except `reqi_ready` (combinational from state, `last_grant` and valids).
- `alu_*` change only at accept edges.
- Reset deassertion: first accept is possible at the first rising edge after `rst_n` goes high.

## Test plan
- Single op: req0 a=0xF0F0F0F0, b=0xFF00FF00, sel=0000 -> `rsp0_valid` 2 cycles after accept; y=0xF000F000; Zero=0, err=0; `op_count`=1.
- Contention: both valid from reset, req0 XOR and req1 OR with a=0x1, b=0x3 -> req0 served first (y=0x2); then req1 with no idle gap beyond 1 cycle (y=0x3); `rsp1_valid` never overlaps `rsp0_valid`.
- Fairness: both held valid for 6 ops -> grant order 0,1,0,1,0,1; `op_count`=6.
- Backpressure: `rsp0_ready`=0 for 10 cycles -> `rsp0_valid` and y stable; both `reqi_ready`=0; `alu_*` unchanged; one cycle after ready=1, IDLE.
- Illegal/Zero: sel=1010 -> y=0, flags=0, err=1. Then sel=0000 with a=0, b=0 -> y=0, Zero=1, err=0.
- Reset mid-op: assert `rst_n`=0 during EXEC -> immediately rsp_valid=0, `op_count`=0, `alu_*`=0. After release, a new req1 command completes normally.
